// File: rtl/tob_builder_if.sv
// rtl/tob_builder_if.sv - L1 update stream bundle between the feed decoder and tob_builder.
interface tob_builder_if #(
  parameter int PX_W  = 32,
  parameter int QTY_W = 64
) ();
  logic             upd_valid;
  logic             upd_ready;
  logic             upd_side;
  logic [PX_W-1:0]  upd_px;
  logic [QTY_W-1:0] upd_qty;
  logic [31:0]      upd_seq;
  logic             upd_snap;

  modport master (output upd_valid, upd_side, upd_px, upd_qty, upd_seq, upd_snap, input upd_ready);
  modport slave  (input upd_valid, upd_side, upd_px, upd_qty, upd_seq, upd_snap, output upd_ready);
endinterface

// File: rtl/tob_builder.sv
// rtl/tob_builder.sv - top-of-book builder with crossed/stale detection.
// Optional sequence-gap checking and snapshot resync under `TOB_SEQ_CHECK_EN.
module tob_builder #(
  parameter int PX_W         = 32,
  parameter int QTY_W        = 64,
  parameter int STALE_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  tob_builder_if.slave     upd,
  output logic [PX_W-1:0]  best_bid_px,
  output logic [PX_W-1:0]  best_ask_px,
  output logic [QTY_W-1:0] best_bid_qty,
  output logic [QTY_W-1:0] best_ask_qty,
  output logic             valid_book,
  output logic [1:0]       book_state,
  output logic             stale,
  output logic             gap_err
);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'b00,
    ST_LIVE    = 2'b01,
    ST_CROSSED = 2'b10,
    ST_RESYNC  = 2'b11
  } state_t;

`ifdef TOB_SEQ_CHECK_EN
  localparam state_t RST_STATE = ST_RESYNC;
`else
  localparam state_t RST_STATE = ST_EMPTY;
`endif

  localparam int CNT_W = $clog2(STALE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALE_CYCLES);

  state_t state, state_nxt;

  logic             ready;
  logic             p_valid;
  logic             p_side;
  logic [PX_W-1:0]  p_px;
  logic [QTY_W-1:0] p_qty;
  logic             bid_ok, ask_ok;
  logic             n_bid_ok, n_ask_ok;
  logic [PX_W-1:0]  n_bid_px, n_ask_px;
  logic [QTY_W-1:0] n_bid_qty, n_ask_qty;
  logic             apply, gap, changed;
  logic             valid_nxt, gap_nxt;
  logic [CNT_W-1:0] stale_cnt;

`ifdef TOB_SEQ_CHECK_EN
  logic [31:0] p_seq;
  logic        p_snap;
  logic [31:0] last_seq;
`else
  logic unused_seq;
  assign unused_seq = ^{upd.upd_seq, upd.upd_snap};
`endif

  assign upd.upd_ready = ready;

  // Accepted updates are registered first and applied one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready   <= 1'b0;
      p_valid <= 1'b0;
      p_side  <= 1'b0;
      p_px    <= '0;
      p_qty   <= '0;
`ifdef TOB_SEQ_CHECK_EN
      p_seq   <= '0;
      p_snap  <= 1'b0;
`endif
    end else begin
      ready   <= 1'b1;
      p_valid <= upd.upd_valid & ready;
      if (upd.upd_valid && ready) begin
        p_side <= upd.upd_side;
        p_px   <= upd.upd_px;
        p_qty  <= upd.upd_qty;
`ifdef TOB_SEQ_CHECK_EN
        p_seq  <= upd.upd_seq;
        p_snap <= upd.upd_snap;
`endif
      end
    end
  end

  always_comb begin
    gap   = 1'b0;
    apply = p_valid;
`ifdef TOB_SEQ_CHECK_EN
    if (p_valid && !p_snap) begin
      if (state == ST_RESYNC) begin
        apply = 1'b0;
      end else if (p_seq != last_seq + 32'd1) begin
        apply = 1'b0;
        gap   = 1'b1;
      end
    end
`endif
  end

  // Candidate book after this edge; a gap keeps prices but forgets both sides.
  always_comb begin
    n_bid_px  = best_bid_px;
    n_ask_px  = best_ask_px;
    n_bid_qty = best_bid_qty;
    n_ask_qty = best_ask_qty;
    n_bid_ok  = bid_ok;
    n_ask_ok  = ask_ok;
    if (gap) begin
      n_bid_ok = 1'b0;
      n_ask_ok = 1'b0;
    end else if (apply) begin
      if (!p_side) begin
        n_bid_ok  = (p_qty != '0);
        n_bid_px  = n_bid_ok ? p_px : '0;
        n_bid_qty = n_bid_ok ? p_qty : '0;
      end else begin
        n_ask_ok  = (p_qty != '0);
        n_ask_px  = n_ask_ok ? p_px : '0;
        n_ask_qty = n_ask_ok ? p_qty : '0;
      end
    end
    changed = p_side ? ((n_ask_px != best_ask_px) || (n_ask_qty != best_ask_qty))
                     : ((n_bid_px != best_bid_px) || (n_bid_qty != best_bid_qty));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_STATE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (gap) begin
      state_nxt = ST_RESYNC;
    end else if (apply) begin
      if (!n_bid_ok || !n_ask_ok) begin
        state_nxt = ST_EMPTY;
      end else if (n_bid_px >= n_ask_px) begin
        state_nxt = ST_CROSSED;
      end else begin
        state_nxt = ST_LIVE;
      end
    end
  end

  always_comb begin
    valid_nxt  = apply && (state_nxt == ST_LIVE) && (changed || (state != ST_LIVE));
    gap_nxt    = gap;
    book_state = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_bid_px  <= '0;
      best_ask_px  <= '0;
      best_bid_qty <= '0;
      best_ask_qty <= '0;
      bid_ok       <= 1'b0;
      ask_ok       <= 1'b0;
      valid_book   <= 1'b0;
      gap_err      <= 1'b0;
    end else begin
      best_bid_px  <= n_bid_px;
      best_ask_px  <= n_ask_px;
      best_bid_qty <= n_bid_qty;
      best_ask_qty <= n_ask_qty;
      bid_ok       <= n_bid_ok;
      ask_ok       <= n_ask_ok;
      valid_book   <= valid_nxt;
      gap_err      <= gap_nxt;
    end
  end

`ifdef TOB_SEQ_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_seq <= '0;
    end else if (apply) begin
      last_seq <= p_seq;
    end
  end
`endif

  // Dropped updates in RESYNC still count as feed activity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stale_cnt <= '0;
    end else if (p_valid) begin
      stale_cnt <= '0;
    end else if (stale_cnt != CNT_MAX) begin
      stale_cnt <= stale_cnt + CNT_W'(1);
    end
  end

  assign stale = (stale_cnt == CNT_MAX);

endmodule

// File: tb/tb_tob_builder.sv
// tb/tb_tob_builder.sv - directed table-driven bench for tob_builder.
module tb_tob_builder;
  localparam int PX_W  = 32;
  localparam int QTY_W = 64;
  localparam int STALE = 8;

`ifdef TOB_SEQ_CHECK_EN
  localparam logic [1:0]  RST_ST = 2'b11;
  localparam logic [31:0] SEQ12  = 32'd12;
`else
  localparam logic [1:0]  RST_ST = 2'b00;
  localparam logic [31:0] SEQ12  = 32'd500;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tob_builder_if #(.PX_W(PX_W), .QTY_W(QTY_W)) upd ();

  logic [PX_W-1:0]  best_bid_px, best_ask_px;
  logic [QTY_W-1:0] best_bid_qty, best_ask_qty;
  logic             valid_book, stale, gap_err;
  logic [1:0]       book_state;

  tob_builder #(.PX_W(PX_W), .QTY_W(QTY_W), .STALE_CYCLES(STALE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .upd          (upd),
    .best_bid_px  (best_bid_px),
    .best_ask_px  (best_ask_px),
    .best_bid_qty (best_bid_qty),
    .best_ask_qty (best_ask_qty),
    .valid_book   (valid_book),
    .book_state   (book_state),
    .stale        (stale),
    .gap_err      (gap_err)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        side;
    logic [31:0] px;
    logic [63:0] qty;
    logic [31:0] seq;
    logic        snap;
    logic [1:0]  st;
    logic [31:0] bpx;
    logic [31:0] apx;
    logic [63:0] bq;
    logic [63:0] aq;
    logic        vb;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Caller is at a negedge; returns at the negedge after the apply edge.
  task automatic send(input logic side, input logic [31:0] px, input logic [63:0] qty,
                      input logic [31:0] seq, input logic snap);
    upd.upd_valid = 1'b1;
    upd.upd_side  = side;
    upd.upd_px    = px;
    upd.upd_qty   = qty;
    upd.upd_seq   = seq;
    upd.upd_snap  = snap;
    @(negedge clk);
    upd.upd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_book(input string name, input logic [1:0] st, input logic [31:0] bpx,
                            input logic [31:0] apx, input logic [63:0] bq, input logic [63:0] aq,
                            input logic vb, input logic ge);
    chk({name, ".state"}, 64'(book_state), 64'(st));
    chk({name, ".bid_px"}, 64'(best_bid_px), 64'(bpx));
    chk({name, ".ask_px"}, 64'(best_ask_px), 64'(apx));
    chk({name, ".bid_qty"}, best_bid_qty, bq);
    chk({name, ".ask_qty"}, best_ask_qty, aq);
    chk({name, ".valid_book"}, 64'(valid_book), 64'(vb));
    chk({name, ".gap_err"}, 64'(gap_err), 64'(ge));
    chk({name, ".stale"}, 64'(stale), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b0, 32'd100,        64'd5, 32'd1,  1'b1, 2'b00, 32'd100,        32'd0,          64'd5, 64'd0, 1'b0};
    vecs[1]  = '{1'b1, 32'd101,        64'd7, 32'd2,  1'b1, 2'b01, 32'd100,        32'd101,        64'd5, 64'd7, 1'b1};
    vecs[2]  = '{1'b0, 32'd101,        64'd3, 32'd3,  1'b0, 2'b10, 32'd101,        32'd101,        64'd3, 64'd7, 1'b0};
    vecs[3]  = '{1'b1, 32'd102,        64'd7, 32'd4,  1'b0, 2'b01, 32'd101,        32'd102,        64'd3, 64'd7, 1'b1};
    vecs[4]  = '{1'b1, 32'd102,        64'd7, 32'd5,  1'b0, 2'b01, 32'd101,        32'd102,        64'd3, 64'd7, 1'b0};
    vecs[5]  = '{1'b1, 32'd102,        64'd0, 32'd6,  1'b0, 2'b00, 32'd101,        32'd0,          64'd3, 64'd0, 1'b0};
    vecs[6]  = '{1'b1, 32'd105,        64'd2, 32'd7,  1'b0, 2'b01, 32'd101,        32'd105,        64'd3, 64'd2, 1'b1};
    vecs[7]  = '{1'b0, 32'd101,        64'd9, 32'd8,  1'b0, 2'b01, 32'd101,        32'd105,        64'd9, 64'd2, 1'b1};
    vecs[8]  = '{1'b1, 32'h8000_0000,  64'd1, 32'd9,  1'b0, 2'b01, 32'd101,        32'h8000_0000,  64'd9, 64'd1, 1'b1};
    vecs[9]  = '{1'b0, 32'h9000_0000,  64'd1, 32'd10, 1'b0, 2'b10, 32'h9000_0000,  32'h8000_0000,  64'd1, 64'd1, 1'b0};
    vecs[10] = '{1'b0, 32'd50,         64'd0, 32'd11, 1'b0, 2'b00, 32'd0,          32'h8000_0000,  64'd0, 64'd1, 1'b0};

    upd.upd_valid = 1'b0;
    upd.upd_side  = 1'b0;
    upd.upd_px    = '0;
    upd.upd_qty   = '0;
    upd.upd_seq   = '0;
    upd.upd_snap  = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset.ready", 64'(upd.upd_ready), 64'd0);
    check_book("reset", RST_ST, 32'd0, 32'd0, 64'd0, 64'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 64'(upd.upd_ready), 64'd1);

    for (int i = 0; i < 11; i++) begin
      send(vecs[i].side, vecs[i].px, vecs[i].qty, vecs[i].seq, vecs[i].snap);
      check_book($sformatf("vec%0d", i), vecs[i].st, vecs[i].bpx, vecs[i].apx,
                 vecs[i].bq, vecs[i].aq, vecs[i].vb, 1'b0);
    end

    send(1'b0, 32'd100, 64'd5, SEQ12, 1'b0);
    check_book("relive", 2'b01, 32'd100, 32'h8000_0000, 64'd5, 64'd1, 1'b1, 1'b0);

`ifdef TOB_SEQ_CHECK_EN
    send(1'b1, 32'h8000_0000, 64'd9, 32'd14, 1'b0);
    check_book("gap", 2'b11, 32'd100, 32'h8000_0000, 64'd5, 64'd1, 1'b0, 1'b1);
    @(negedge clk);
    chk("gap_pulse_end", 64'(gap_err), 64'd0);
    send(1'b0, 32'd200, 64'd1, 32'd15, 1'b0);
    check_book("resync_drop", 2'b11, 32'd100, 32'h8000_0000, 64'd5, 64'd1, 1'b0, 1'b0);
    send(1'b0, 32'd100, 64'd5, 32'd20, 1'b1);
    check_book("snap_bid", 2'b00, 32'd100, 32'h8000_0000, 64'd5, 64'd1, 1'b0, 1'b0);
    send(1'b1, 32'h8000_0000, 64'd1, 32'd21, 1'b1);
    check_book("snap_ask", 2'b01, 32'd100, 32'h8000_0000, 64'd5, 64'd1, 1'b1, 1'b0);
    send(1'b0, 32'd100, 64'd6, 32'hFFFF_FFFF, 1'b1);
    check_book("seq_max", 2'b01, 32'd100, 32'h8000_0000, 64'd6, 64'd1, 1'b1, 1'b0);
    send(1'b1, 32'h8000_0000, 64'd2, 32'd0, 1'b0);
    check_book("seq_wrap", 2'b01, 32'd100, 32'h8000_0000, 64'd6, 64'd2, 1'b1, 1'b0);
`else
    send(1'b0, 32'd100, 64'd6, 32'd900, 1'b0);
    check_book("seq_ignored", 2'b01, 32'd100, 32'h8000_0000, 64'd6, 64'd1, 1'b1, 1'b0);
`endif

    repeat (7) @(negedge clk);
    chk("stale_cnt7", 64'(stale), 64'd0);
    @(negedge clk);
    chk("stale_cnt8", 64'(stale), 64'd1);
    chk("stale_no_pulse", 64'(valid_book), 64'd0);
    repeat (3) @(negedge clk);
    chk("stale_hold", 64'(stale), 64'd1);
    chk("stale_book_held", 64'(best_bid_qty), 64'd6);
    send(1'b0, 32'd100, 64'd11, 32'd1, 1'b0);
    chk("stale_clear", 64'(stale), 64'd0);
    chk("stale_clear_pulse", 64'(valid_book), 64'd1);
    chk("stale_clear_qty", best_bid_qty, 64'd11);

    repeat (6) @(negedge clk);
    upd.upd_valid = 1'b1;
    upd.upd_side  = 1'b0;
    upd.upd_px    = 32'd100;
    upd.upd_qty   = 64'd11;
    upd.upd_seq   = 32'd2;
    upd.upd_snap  = 1'b0;
    @(negedge clk);
    upd.upd_valid = 1'b0;
    chk("tie_before", 64'(stale), 64'd0);
    @(negedge clk);
    chk("tie_update_wins", 64'(stale), 64'd0);
    chk("tie_dup_no_pulse", 64'(valid_book), 64'd0);
    chk("tie_state", 64'(book_state), 64'd1);
    repeat (7) @(negedge clk);
    chk("tie_cnt_reset", 64'(stale), 64'd0);
    send(1'b0, 32'd100, 64'd12, 32'd3, 1'b0);
    chk("after_tie_pulse", 64'(valid_book), 64'd1);
    chk("after_tie_stale", 64'(stale), 64'd0);

    upd.upd_valid = 1'b1;
    upd.upd_side  = 1'b0;
    upd.upd_px    = 32'd300;
    upd.upd_qty   = 64'd1;
    upd.upd_seq   = 32'd4;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    upd.upd_valid = 1'b0;
    chk("midrst.ready", 64'(upd.upd_ready), 64'd0);
    check_book("midrst", RST_ST, 32'd0, 32'd0, 64'd0, 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst.ready", 64'(upd.upd_ready), 64'd1);
    check_book("post_rst", RST_ST, 32'd0, 32'd0, 64'd0, 64'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
